mmm_scheduler: RTL and testbench
================================

# mmm_scheduler

Round-robin scheduler sharing one Montgomery multiplier core (K-bit, start/done handshake) among NREQ requesters. It captures a winner's operands, runs the core through a full start/done/release handshake, rejects even moduli without touching the core, and guards against a hung core with a timeout. The scheduler sits between the requester ports and the single multiplier instance in the modular-arithmetic subsystem.

## Interface
- K, 8, operand/result width; matches the multiplier core
- NREQ, 4, number of requesters (≥2)
- TIMEOUT, 64, max cycles in ISSUE waiting for core_done (must exceed K+4)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has an operation pending
- req_A, req_B, req_m  in  NREQ*K each  operands, slice i = [i*K +: K]
- req_ready  out  NREQ  one-hot accept; a transfer occurs when req_valid[i] & req_ready[i]
- rsp_valid  out  1  one-cycle result strobe, no backpressure
- rsp_id  out  $clog2(NREQ)  requester index of the result
- rsp_data  out  K  Montgomery product; 0 when rsp_err
- rsp_err  out  1  1 = even modulus or timeout
- core_start  out  1  to core start, level-held
- core_A, core_B, core_m  out  K  registered operands to core
- core_P  in  K  core result
- core_done  in  1  core done level

## Operation
- Reset (sync): state IDLE, ptr = NREQ-1, and all outputs 0 (req_ready, rsp_*, core_*). The core is reset separately by its own rst connection.
- States: IDLE, ISSUE, RESP, DRAIN.
- IDLE: the winner is the first i with req_valid[i], searching ptr+1, ptr+2, … mod NREQ. req_ready is one-hot to the winner, combinational from req_valid and state. It is 0 outside IDLE and 0 if no request is valid.
- On accept:
  - Capture A, B, m into core_A/B/m and set id = winner.
  - Set ptr = winner.
  - If m[0] = 0: go to RESP with err = 1. The core is not started.
  - Otherwise: core_start <= 1, clear the timeout counter, go to ISSUE.
- ISSUE: core_start held 1 and the timeout counter increments each cycle.
  - core_done = 1: latch core_P and go to RESP with err = 0.
  - Counter reaches TIMEOUT-1 without core_done: go to RESP with err = 1.
- RESP: rsp_valid = 1 for exactly this cycle, with rsp_id/rsp_data/rsp_err. core_start <= 0. Go to DRAIN.
- DRAIN: core_start stays 0. Return to IDLE when core_done = 0.
  - In the even-m and timeout cases core_done is already 0, so DRAIN lasts 1 cycle.
  - This guarantees the core has returned to its idle state before the next start.
- rsp_valid, rsp_id, rsp_data and rsp_err are registered. rsp_data and rsp_err hold their last values when rsp_valid = 0.
- Operands are never modified. The result is passed through as core_P, which may be in [0, 2m); there is no final subtraction here.
- Fairness: each requester waits at most NREQ-1 other operations after asserting req_valid.
- Simultaneous events:
  - A new req_valid arriving during ISSUE/RESP/DRAIN is not accepted until IDLE.
  - Deasserting req_valid before accept simply removes that requester from arbitration.
- rst asserted in any state aborts the operation. The next cycle is IDLE with core_start = 0 and no response is issued.

## Timing
- Accept at cycle t (IDLE, handshake). core_start = 1 from t+1.
- The core asserts core_done at cycle t+1+K+1 (for K = 8: t+10), as seen by the scheduler.
- RESP, i.e. rsp_valid = 1, at the cycle after core_done is sampled: t+K+3.
- core_done falls 2 cycles after core_start falls. The scheduler is back in IDLE at ≈t+K+6 and can accept the next request in that cycle.
- Even-m reject: accept at t, rsp_valid at t+1, IDLE at t+3.
- Timeout: rsp_valid at t+1+TIMEOUT.
- Throughput: one operation per ≈K+6 cycles.

## Structure
- Shared package `mmm_pkg`:
  - state encoding localparams (IDLE/ISSUE/RESP/DRAIN)
  - default K
  - function rr_next(ptr, valid) returning the round-robin winner index
- One natural sub-module, `rr_arbiter`: combinational one-hot grant from req_valid and ptr.
- FSM, operand registers, timeout counter and response registers live in `mmm_scheduler`.
- The testbench instantiates `mmm_scheduler` with the real multiplier core.

## Test plan
- Single op: req 0 with A=5, B=7, m=13 → rsp_valid once, rsp_id=0, rsp_data=1, rsp_err=0, K+3 cycles after accept.
- All 4 requesters valid continuously with distinct operands → grant order 0,1,2,3,0,… and each result correct (e.g. A=5, B=7, m=13 gives 1 on every grant to that slot).
- Even modulus: req 2 with m=12 → rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0, core_start never asserted.
- Timeout: stub core with core_done tied 0 → rsp_err=1 exactly TIMEOUT+1 cycles after accept, then IDLE and the next request is accepted.
- Reset mid-ISSUE: rst pulsed 3 cycles after accept → core_start=0 and no rsp_valid; after release, ptr=NREQ-1 so requester 0 wins first.
- Back-to-back: core_done observed low before the next core_start rises; no second start while core_done=1.

Source files
------------

// File: rtl/mmm_pkg.sv
// Shared definitions for the Montgomery-multiplier scheduler: FSM state
// encoding, default operand width and the round-robin winner search.
package mmm_pkg;

  // Default operand/result width of the multiplier core.
  localparam int MMM_K = 8;

  // Upper bound on requesters that rr_next can search.
  localparam int RR_MAX = 16;
  localparam int RR_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

  // First index with valid set, searching ptr+1, ptr+2, ... mod nreq.
  // Returns ptr when nothing is valid; callers qualify with |valid.
  // Walking the offsets downward lets the smallest offset overwrite last,
  // which keeps the loop bound constant for synthesis.
  function automatic int rr_next(input int ptr, input logic [RR_MAX-1:0] valid,
                                 input int nreq);
    int idx;
    rr_next = ptr;
    for (int off = RR_MAX; off >= 1; off--) begin
      if (off <= nreq) begin
        idx = (ptr + off) % nreq;
        if (valid[idx[RR_W-1:0]]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/mmm_scheduler_if.sv
// Requester, response and multiplier-core signals of the scheduler.
// slave = scheduler side, master = requesters plus the core.
interface mmm_scheduler_if #(
  parameter int K    = 8,
  parameter int NREQ = 4
);
  localparam int IW = $clog2(NREQ);

  // Requester ports, operand slice i = [i*K +: K]
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*K-1:0] req_A;
  logic [NREQ*K-1:0] req_B;
  logic [NREQ*K-1:0] req_m;
  logic [NREQ-1:0]   req_ready;

  // Response strobe, no backpressure
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [K-1:0]      rsp_data;
  logic              rsp_err;

  // Multiplier core handshake
  logic              core_start;
  logic [K-1:0]      core_A;
  logic [K-1:0]      core_B;
  logic [K-1:0]      core_m;
  logic [K-1:0]      core_P;
  logic              core_done;

  modport slave (
    input  req_valid, req_A, req_B, req_m, core_P, core_done,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           core_start, core_A, core_B, core_m
  );

  modport master (
    output req_valid, req_A, req_B, req_m, core_P, core_done,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           core_start, core_A, core_B, core_m
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first valid
// requester after ptr (the last requester served).
module rr_arbiter import mmm_pkg::*; #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   gnt_id,
  output logic            gnt_any
);

  // Winner search plus one-hot decode of the winning index.
  always_comb begin
    gnt_any = |valid;
    gnt_id  = IW'(rr_next(int'(ptr), RR_MAX'(valid), NREQ));
    grant   = '0;
    if (gnt_any) grant[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/mmm_scheduler.sv
// Round-robin scheduler in front of a single Montgomery multiplier core.
// Captures the winner's operands, runs the core start/done/release handshake,
// rejects even moduli without starting the core, and times out a hung core.
module mmm_scheduler import mmm_pkg::*; #(
  parameter int K       = MMM_K,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  mmm_scheduler_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  sched_state_t    state, state_nxt;
  logic [IW-1:0]   ptr;          // last requester accepted; also the id in flight
  logic [CW-1:0]   to_cnt;
  logic            to_hit;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gnt_id;
  logic            gnt_any;
  logic            accept;
  logic [K-1:0]    sel_A, sel_B, sel_m;

  logic            core_start_q;
  logic [K-1:0]    core_A_q, core_B_q, core_m_q;
  logic            rsp_valid_q;
  logic [IW-1:0]   rsp_id_q;
  logic [K-1:0]    rsp_data_q;
  logic            rsp_err_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid   (bus.req_valid),
    .ptr     (ptr),
    .grant   (grant),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign sel_A  = bus.req_A[gnt_id*K +: K];
  assign sel_B  = bus.req_B[gnt_id*K +: K];
  assign sel_m  = bus.req_m[gnt_id*K +: K];

  // Grants are only offered while idle, so requests that arrive mid-operation
  // simply wait for the next IDLE cycle.
  assign accept        = (state == IDLE) && gnt_any;
  assign bus.req_ready = (state == IDLE) ? grant : '0;
  assign to_hit        = (to_cnt == TO_LAST);

  assign bus.core_start = core_start_q;
  assign bus.core_A     = core_A_q;
  assign bus.core_B     = core_B_q;
  assign bus.core_m     = core_m_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;

  // State register; reset aborts whatever is in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. DRAIN waits for core_done to fall so the core is back
  // at idle before it can see another start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = sel_m[0] ? ISSUE : RESP;
      ISSUE:   if (bus.core_done || to_hit) state_nxt = RESP;
      RESP:    state_nxt = DRAIN;
      DRAIN:   if (!bus.core_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, core start, timeout counter and response registers.
  // rsp_data/rsp_err only change on entry to RESP so they hold between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= IW'(NREQ - 1);
      to_cnt       <= '0;
      core_start_q <= 1'b0;
      core_A_q     <= '0;
      core_B_q     <= '0;
      core_m_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      rsp_valid_q <= (state_nxt == RESP);
      case (state)
        IDLE: begin
          if (accept) begin
            core_A_q <= sel_A;
            core_B_q <= sel_B;
            core_m_q <= sel_m;
            ptr      <= gnt_id;
            to_cnt   <= '0;
            if (sel_m[0]) begin
              core_start_q <= 1'b1;
            end else begin
              // Even modulus: reject without touching the core.
              rsp_id_q   <= gnt_id;
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          to_cnt <= to_cnt + 1'b1;
          if (bus.core_done) begin
            rsp_id_q   <= ptr;
            rsp_data_q <= bus.core_P;
            rsp_err_q  <= 1'b0;
          end else if (to_hit) begin
            rsp_id_q   <= ptr;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        RESP: begin
          core_start_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmm_scheduler.sv
// Bench for mmm_scheduler with a behavioural Montgomery core: table-driven
// single ops, timeout, reset abort, continuous round-robin and random rounds.
module tb_mmm_scheduler;

  localparam int K       = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic stub = 1'b0;

  int n_pass = 0;
  int n_tot  = 0;

  int   starts     = 0;
  int   rsp_cnt    = 0;
  int   viol       = 0;
  logic prev_start = 1'b0;

  logic [K-1:0] c_P    = '0;
  logic         c_done = 1'b0;
  logic         c_rel  = 1'b0;
  int           c_cnt  = 0;

  mmm_scheduler_if #(.K(K), .NREQ(NREQ)) bus();

  mmm_scheduler #(.K(K), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.core_P    = c_P;
  assign bus.core_done = stub ? 1'b0 : c_done;

  // Montgomery product a*b*2^-K mod m, found by searching x with x*2^K == a*b.
  function automatic int mont_ref(input int a, input int b, input int m);
    int ab;
    if (m <= 0) return 0;
    ab = (a * b) % m;
    for (int x = 0; x < m; x++)
      if (((x << K) % m) == ab) return x;
    return 0;
  endfunction

  // Core model: done K+1 cycles after start is seen, released 2 cycles after
  // start drops.
  always @(posedge clk) begin
    if (rst) begin
      c_cnt <= 0; c_done <= 1'b0; c_rel <= 1'b0; c_P <= '0;
    end else if (c_rel) begin
      c_done <= 1'b0; c_rel <= 1'b0; c_cnt <= 0;
    end else if (c_done) begin
      if (!bus.core_start) c_rel <= 1'b1;
    end else if (bus.core_start) begin
      if (c_cnt == K) begin
        c_done <= 1'b1;
        c_P    <= K'(mont_ref(int'(bus.core_A), int'(bus.core_B), int'(bus.core_m)));
      end else begin
        c_cnt <= c_cnt + 1;
      end
    end else begin
      c_cnt <= 0;
    end
  end

  // Start-edge / response counters and start-while-done detector.
  always @(negedge clk) begin
    if (bus.core_start === 1'b1 && prev_start === 1'b0) begin
      starts <= starts + 1;
      if (bus.core_done === 1'b1) viol <= viol + 1;
    end
    if (bus.rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
    prev_start <= bus.core_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  task automatic set_ops(input int id, input int a, input int b, input int m);
    bus.req_A[id*K +: K] = K'(a);
    bus.req_B[id*K +: K] = K'(b);
    bus.req_m[id*K +: K] = K'(m);
  endtask

  // Returns in the cycle in which a grant is visible (bounded).
  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      if (bus.req_ready != '0) ok = 1'b1;
      else tick();
    end
  endtask

  // Waits (bounded) for rsp_valid; lat counts cycles from the cycle entered.
  task automatic wait_rsp(output bit ok, inout int lat);
    ok = 1'b0;
    while (!ok && lat < 300) begin
      if (bus.rsp_valid) ok = 1'b1;
      else begin tick(); lat++; end
    end
  endtask

  // One isolated op; lat = cycles from accept to rsp_valid.
  task automatic do_op(input int id, input int a, input int b, input int m,
                       output int lat, output int rid, output int rdata,
                       output int rerr, output int nst);
    bit ok;
    int s0;
    set_ops(id, a, b, m);
    bus.req_valid     = '0;
    bus.req_valid[id] = 1'b1;
    s0 = starts;
    wait_grant(ok);
    chk("accept_seen", int'(ok), 1);
    tick();
    bus.req_valid = '0;
    lat = 1;
    wait_rsp(ok, lat);
    chk("rsp_seen", int'(ok), 1);
    rid   = int'(bus.rsp_id);
    rdata = int'(bus.rsp_data);
    rerr  = int'(bus.rsp_err);
    repeat (6) tick();
    nst = starts - s0;
  endtask

  typedef struct {
    int id; int a; int b; int m;
    int lat; int data; int err;
  } vec_t;

  vec_t vt[8];
  int   rr_exp[4];

  initial begin
    int  lat, rid, rdata, rerr, nst, r0, w, mptr, mask, idx;
    int  ra[NREQ], rb[NREQ], rm[NREQ];
    bit  ok;

    vt[0] = '{0,   5,   7,  13, K+3,  1, 0};
    vt[1] = '{1,   1,   1,  13, K+3,  3, 0};
    vt[2] = '{2,   5,   7,  12,   1,  0, 1};
    vt[3] = '{3,  16,  16, 255, K+3,  1, 0};
    vt[4] = '{0, 200,   3, 255, K+3, 90, 0};
    vt[5] = '{3,   3,   5,   7, K+3,  2, 0};
    vt[6] = '{1,  12,  12,  13, K+3,  3, 0};
    vt[7] = '{3,   9,   9, 254,   1,  0, 1};
    rr_exp = '{1, 3, 1, 2};

    bus.req_valid = '0;
    bus.req_A = '0; bus.req_B = '0; bus.req_m = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_req_ready",  int'(bus.req_ready), 0);
    chk("rst_rsp_valid",  int'(bus.rsp_valid), 0);
    chk("rst_rsp_data",   int'(bus.rsp_data), 0);
    chk("rst_rsp_err",    int'(bus.rsp_err), 0);
    chk("rst_core_start", int'(bus.core_start), 0);
    chk("rst_core_m",     int'(bus.core_m), 0);
    bus.req_valid = '1;
    #1;
    chk("rst_first_grant", int'(bus.req_ready), 1);
    bus.req_valid = '0;
    tick();

    // Table-driven single operations
    for (int i = 0; i < 8; i++) begin
      do_op(vt[i].id, vt[i].a, vt[i].b, vt[i].m, lat, rid, rdata, rerr, nst);
      chk($sformatf("vec%0d_id", i),     rid,   vt[i].id);
      chk($sformatf("vec%0d_data", i),   rdata, vt[i].data);
      chk($sformatf("vec%0d_err", i),    rerr,  vt[i].err);
      chk($sformatf("vec%0d_lat", i),    lat,   vt[i].lat);
      chk($sformatf("vec%0d_starts", i), nst,   vt[i].m % 2);
    end

    // Timeout with a core that never finishes, then a normal op
    stub = 1'b1;
    do_op(1, 5, 7, 13, lat, rid, rdata, rerr, nst);
    chk("to_lat",    lat,   TIMEOUT + 1);
    chk("to_err",    rerr,  1);
    chk("to_data",   rdata, 0);
    chk("to_id",     rid,   1);
    chk("to_starts", nst,   1);
    stub = 1'b0;
    do_op(2, 3, 5, 7, lat, rid, rdata, rerr, nst);
    chk("post_to_data", rdata, 2);
    chk("post_to_err",  rerr,  0);
    chk("post_to_lat",  lat,   K + 3);

    // Reset three cycles after accept aborts the op
    set_ops(2, 5, 7, 13);
    bus.req_valid = 4'b0100;
    wait_grant(ok);
    chk("abort_accept", int'(ok), 1);
    tick();
    bus.req_valid = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_core_start", int'(bus.core_start), 0);
    chk("abort_rsp_valid",  int'(bus.rsp_valid), 0);
    r0 = rsp_cnt;
    repeat (20) tick();
    chk("abort_no_rsp", rsp_cnt - r0, 0);

    // All requesters held valid: strict rotation from requester 0
    set_ops(0, 5, 7, 13);
    set_ops(1, 1, 1, 13);
    set_ops(2, 16, 16, 255);
    set_ops(3, 3, 5, 7);
    bus.req_valid = '1;
    #1;
    chk("rr_first_grant", int'(bus.req_ready), 1);
    for (int n = 0; n < 6; n++) begin
      tick();
      w = 0;
      wait_rsp(ok, w);
      chk("rr_rsp_seen", int'(ok), 1);
      chk("rr_id",   int'(bus.rsp_id),   n % NREQ);
      chk("rr_data", int'(bus.rsp_data), rr_exp[n % NREQ]);
      chk("rr_err",  int'(bus.rsp_err),  0);
      if (n == 5) bus.req_valid = '0;
    end
    repeat (8) tick();
    chk("no_start_while_done", viol, 0);

    // Random rounds against a round-robin / Montgomery reference
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mptr = NREQ - 1;
    for (int r = 0; r < 30; r++) begin
      mask = int'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        rm[i] = int'($urandom_range(2, 255));
        if ($urandom_range(0, 3) != 0) rm[i] = rm[i] | 1;
        ra[i] = int'($urandom_range(0, rm[i] - 1));
        rb[i] = int'($urandom_range(0, rm[i] - 1));
        set_ops(i, ra[i], rb[i], rm[i]);
      end
      w = -1;
      for (int off = 1; off <= NREQ; off++) begin
        idx = (mptr + off) % NREQ;
        if (w < 0 && ((mask >> idx) & 1) == 1) w = idx;
      end
      bus.req_valid = NREQ'(mask);
      wait_grant(ok);
      chk("rand_grant", int'(bus.req_ready), 1 << w);
      tick();
      bus.req_valid = '0;
      lat = 1;
      wait_rsp(ok, lat);
      chk("rand_rsp_seen", int'(ok), 1);
      chk("rand_id",  int'(bus.rsp_id), w);
      chk("rand_err", int'(bus.rsp_err), (rm[w] % 2 == 0) ? 1 : 0);
      chk("rand_data", int'(bus.rsp_data),
          (rm[w] % 2 == 0) ? 0 : mont_ref(ra[w], rb[w], rm[w]));
      mptr = w;
      repeat (5) tick();
    end
    chk("rand_no_start_while_done", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
